// File: rtl/mult_error_stats.sv
// Error-distance statistics collector for an approximate multiplier.
// Collects N_SAMPLES accepted (y_approx, y_exact) pairs. For the run it reports the
// error count, the maximum error distance, the sum of error distances and the
// truncated mean error distance.
module mult_error_stats #(
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned W         = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic [W-1:0]                          y_approx,
  input  logic [W-1:0]                          y_exact,
  output logic                                  in_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(N_SAMPLES):0]            err_count,
  output logic [W:0]                            max_ed,
  output logic [W+$clog2(N_SAMPLES):0]          sum_ed,
  output logic [W:0]                            mean_ed
);

  localparam int unsigned LG  = $clog2(N_SAMPLES);
  localparam int unsigned EDW = W + 1;
  localparam int unsigned SW  = EDW + LG;
  localparam int unsigned CW  = LG + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    err_q;
  logic [EDW-1:0]   max_q;
  logic [SW-1:0]    sum_q;
  logic [EDW-1:0]   mean_q;
  logic             busy_q, done_q;

  logic             accept;
  logic             last;
  logic [EDW-1:0]   diff;
  logic [EDW-1:0]   ed;

  // Differences are taken at W+1 bits so the widest signed gap cannot overflow.
  assign diff     = {y_approx[W-1], y_approx} - {y_exact[W-1], y_exact};
  assign ed       = diff[EDW-1] ? (~diff + EDW'(1)) : diff;

  assign in_ready = (state_q == StRun);
  assign accept   = in_ready && in_valid;
  assign last     = accept && (cnt_q == CW'(N_SAMPLES - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic. A start pulse is only acted on in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun:    if (last)  state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Status flags are registered from the next state, so they stay aligned with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != StIdle);
      done_q <= (state_d == StFinish);
    end
  end

  // Accumulators: cleared by an accepted start, updated on each accepted sample,
  // and the mean is loaded while leaving FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      err_q  <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      mean_q <= '0;
    end else if (state_q == StIdle && start) begin
      cnt_q  <= '0;
      err_q  <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      mean_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + CW'(1);
      err_q <= err_q + CW'(ed != '0);
      sum_q <= sum_q + SW'(ed);
      if (ed > max_q) max_q <= ed;
    end else if (state_q == StFinish) begin
      mean_q <= EDW'(sum_q >> LG);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign max_ed    = max_q;
  assign sum_ed    = sum_q;
  assign mean_ed   = mean_q;

endmodule
